// File: rtl/countdown_core.sv
// BCD min:sec:hundredths countdown timer with preset capture, pause/resume and
// optional auto-reload on expiry. Count registers drive the outputs directly.
module countdown_core #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk_core,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] min_i,
    input  logic [7:0] sec_i,
    input  logic [7:0] ms_10_i,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic [7:0] ms_10_o,
    output logic       busy,
    output logic       done,
    output logic       load_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] state;
    logic [7:0] pre_min;
    logic [7:0] pre_sec;
    logic [7:0] pre_ms;

    logic       preset_valid;
    logic       count_zero;
    logic       count_one;
    logic [7:0] min_nx;
    logic [7:0] sec_nx;
    logic [7:0] ms_nx;

    // Decrement one packed-BCD field; a zero field wraps to its maximum and the
    // caller treats that as a borrow into the next field.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] wrap);
        if (v == 8'h00)
            return wrap;
        else if (v[3:0] == 4'h0)
            return {v[7:4] - 4'd1, 4'h9};
        else
            return v - 8'd1;
    endfunction

    always_comb begin
        preset_valid = (min_i[7:4]   <= 4'd9) && (min_i[3:0]   <= 4'd9) &&
                       (sec_i[7:4]   <= 4'd5) && (sec_i[3:0]   <= 4'd9) &&
                       (ms_10_i[7:4] <= 4'd9) && (ms_10_i[3:0] <= 4'd9);
        count_zero   = (min_o == 8'h00) && (sec_o == 8'h00) && (ms_10_o == 8'h00);
        count_one    = (min_o == 8'h00) && (sec_o == 8'h00) && (ms_10_o == 8'h01);
        ms_nx        = bcd_dec(ms_10_o, 8'h99);
        sec_nx       = (ms_10_o == 8'h00) ? bcd_dec(sec_o, 8'h59) : sec_o;
        min_nx       = (ms_10_o == 8'h00 && sec_o == 8'h00) ? bcd_dec(min_o, 8'h99) : min_o;
    end

    // NOTE: state registers use non-blocking assignments so every branch reads
    // the pre-edge values and the block behaves as parallel flops.
    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            min_o    <= 8'h00;
            sec_o    <= 8'h00;
            ms_10_o  <= 8'h00;
            pre_min  <= 8'h00;
            pre_sec  <= 8'h00;
            pre_ms   <= 8'h00;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else if (!en) begin
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            // Commands ignored in the current state fall through to lower ones.
            if (clear) begin
                state   <= S_IDLE;
                min_o   <= 8'h00;
                sec_o   <= 8'h00;
                ms_10_o <= 8'h00;
            end else if (load && state != S_RUN) begin
                if (preset_valid) begin
                    pre_min <= min_i;
                    pre_sec <= sec_i;
                    pre_ms  <= ms_10_i;
                    min_o   <= min_i;
                    sec_o   <= sec_i;
                    ms_10_o <= ms_10_i;
                    state   <= S_IDLE;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (start && (state == S_IDLE || state == S_PAUSE)) begin
                if (count_zero) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end else begin
                    state <= S_RUN;
                end
            end else if (pause && state == S_RUN) begin
                state <= S_PAUSE;
            end else if (state == S_RUN) begin
                if (count_zero) begin
                    // Only reachable with auto-reload: expired last edge, restart now.
                    min_o   <= pre_min;
                    sec_o   <= pre_sec;
                    ms_10_o <= pre_ms;
                end else begin
                    min_o   <= min_nx;
                    sec_o   <= sec_nx;
                    ms_10_o <= ms_nx;
                    if (count_one) begin
                        done <= 1'b1;
                        if (!AUTO_RELOAD)
                            state <= S_DONE;
                    end
                end
            end
        end
    end

    assign busy = (state == S_RUN);

endmodule

// File: doc/countdown_core.md
COUNTDOWN_CORE -- requirements
Module: countdown_core

Interface
REQ-001 Parameter AUTO_RELOAD, default 0; 1 = reload preset and keep running on expiry, 0 = stop at zero.
REQ-002 clk_core  input  1  100 Hz count clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  global enable; 0 freezes count, state and preset.
REQ-005 load  input  1  level-sampled; capture preset from min_i/sec_i/ms_10_i.
REQ-006 min_i  input  8  preset minutes, packed BCD {tens,units}.
REQ-007 sec_i  input  8  preset seconds, packed BCD.
REQ-008 ms_10_i  input  8  preset hundredths, packed BCD.
REQ-009 start  input  1  begin or resume counting.
REQ-010 pause  input  1  freeze counting while running.
REQ-011 clear  input  1  synchronous return to IDLE with zero count.
REQ-012 min_o  output  8  current minutes, packed BCD, registered.
REQ-013 sec_o  output  8  current seconds, packed BCD, registered.
REQ-014 ms_10_o  output  8  current hundredths, packed BCD, registered.
REQ-015 busy  output  1  1 while in RUN.
REQ-016 done  output  1  one-cycle expiry pulse.
REQ-017 load_err  output  1  one-cycle pulse on rejected load.

Function
REQ-018 States: IDLE, RUN, PAUSE, DONE; state and outputs change only on clk_core rising edge with en=1 or on rst.
REQ-019 en=0: count, state and preset register hold; done and load_err are 0.
REQ-020 Command priority per cycle: clear > load > start > pause.
REQ-021 clear (any state): count <= 00:00:00, state <= IDLE; preset register unchanged.
REQ-022 Valid preset: every BCD digit <= 9 and seconds tens <= 5; minutes range 00-99.
REQ-023 load in IDLE/PAUSE/DONE, valid: preset register and count <= inputs next edge, state <= IDLE.
REQ-024 load with invalid preset: count, preset and state unchanged; load_err = 1 for that cycle.
REQ-025 load in RUN: ignored, no load_err.
REQ-026 start in IDLE/PAUSE with nonzero count: state <= RUN; first decrement on the following edge.
REQ-027 start in IDLE/PAUSE with count 00:00:00: state <= DONE, done = 1 for that cycle.
REQ-028 start in RUN/DONE: ignored.
REQ-029 pause in RUN: state <= PAUSE, no decrement that edge; pause in other states ignored.
REQ-030 RUN: each enabled edge decrements count by 00:00:01 in BCD; hundredths 00 -> 99 with borrow; seconds 00 -> 59 with borrow into minutes.
REQ-031 RUN transition 00:00:01 -> 00:00:00: done = 1 on the same edge; AUTO_RELOAD=0: state <= DONE, count holds 00:00:00.
REQ-032 AUTO_RELOAD=1: edge after count reaches 00:00:00 loads preset, state stays RUN; done pulses once per expiry.
REQ-033 Outputs never show invalid BCD; no wrap below 00:00:00.
REQ-034 busy = 1 exactly when state is RUN.

Reset
REQ-035 rst low: state IDLE, min_o/sec_o/ms_10_o = 8'h00, preset = 00:00:00, busy = 0, done = 0, load_err = 0, immediately without clock.
REQ-036 rst asserted mid-RUN aborts the count; no done pulse generated.
REQ-037 After rst release, first enabled edge obeys REQ-020..034 normally.

Verification
REQ-038 load 00:01:05, start, en=1 -> 105 decrement edges later outputs 00:00:00, done=1 for exactly that cycle, busy=0 after.
REQ-039 load 01:00:00, start -> first decrement shows min_o=00, sec_o=59, ms_10_o=99.
REQ-040 Running from 00:01:05, pause after 10 decrements (00:00:95), hold 20 cycles -> outputs stay 00:00:95; start -> resumes 00:00:94.
REQ-041 load min_i=00, sec_i=8'h60, ms_10_i=00 -> load_err pulse, outputs and state unchanged; ms_10_i=8'h0A also rejected.
REQ-042 Async rst low mid-RUN at 00:00:40 -> outputs 00:00:00, busy=0 before next clock edge.
REQ-043 AUTO_RELOAD=1, load 00:00:03, start -> sequence 02, 01, 00 (done=1), 03, 02, ...; en=0 for 5 cycles mid-sequence freezes value.
